// File: rtl/reflet_irq_ctrl.sv
// reflet_irq_ctrl: latches 4 irq lines (edge/level) into W1C PENDING, masks them onto reflet_cpu interrupt_request.
// Latency: irq_in rising before edge k -> request high in cycle k+1 (k+3 with IRQ_SYNC_EN defined); reads are combinational.
// Backpressure: none on the bus; enable=0 freezes MASK/MODE writes and PENDING clears while capture keeps running.
module reflet_irq_ctrl #(
  parameter int unsigned         wordsize   = 16,
  parameter logic [wordsize-1:0] base_addr  = '0,
  parameter logic [3:0]          mask_reset = 4'hF,
  parameter logic [3:0]          mode_reset = 4'hF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [3:0]          irq_in,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic [3:0]          interrupt_request
);

  logic [3:0] pending_q, pending_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] mode_q, mode_d;
  logic [3:0] prev_q, prev_d;
  logic [3:0] sample;

`ifdef IRQ_SYNC_EN
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;

  // Two-stage synchronizer for lines asynchronous to clk.
  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
  end

  // Synchronizer flops clear to zero on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 4'h0;
      sync2_q <= 4'h0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = irq_in;
`endif

  // Address decode: full-width compare, window never wraps past the top of the address space.
  logic [wordsize-1:0] offset;
  logic                in_window;
  logic                wr_acc;
  logic [3:0]          set_vec;
  logic [3:0]          clr_vec;
  logic                irq_any;
  logic [1:0]          irq_idx;
  logic                unused_data_hi;

  assign offset         = addr - base_addr;
  assign in_window      = (addr >= base_addr) && (offset < wordsize'(4));
  assign wr_acc         = write_en & enable & in_window;
  assign unused_data_hi = ^data_in[wordsize-1:4];

  // Next-state: capture always runs; clears and config writes need an accepted bus write. Set beats clear.
  always_comb begin
    set_vec   = (sample & ~prev_q & mode_q) | (sample & ~mode_q);
    clr_vec   = (wr_acc && offset[1:0] == 2'd0) ? data_in[3:0] : 4'h0;
    pending_d = (pending_q & ~clr_vec) | set_vec;
    mask_d    = mask_q;
    mode_d    = mode_q;
    if (wr_acc && offset[1:0] == 2'd1) mask_d = data_in[3:0];
    if (wr_acc && offset[1:0] == 2'd2) mode_d = data_in[3:0];
    prev_d    = sample;
  end

  // State registers; prev resets high so a line already asserted at reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 4'h0;
      mask_q    <= mask_reset;
      mode_q    <= mode_reset;
      prev_q    <= 4'hF;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      prev_q    <= prev_d;
    end
  end

  assign interrupt_request = pending_q & mask_q;

  // STATUS fields: any-request flag and lowest requesting index.
  always_comb begin
    irq_any = |interrupt_request;
    irq_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (interrupt_request[i]) irq_idx = 2'(i);
    end
  end

  // Read mux; zero outside the window so several slaves can be ORed onto one bus.
  always_comb begin
    data_out = '0;
    if (in_window) begin
      case (offset[1:0])
        2'd0:    data_out[3:0] = pending_q;
        2'd1:    data_out[3:0] = mask_q;
        2'd2:    data_out[3:0] = mode_q;
        default: data_out[3:0] = {irq_any, 1'b0, irq_idx};
      endcase
    end
  end

endmodule
